// File: rtl/l2_pkg.sv
// Shared widths, types and constants for the L2 request responder.
package l2_pkg;

  // Width of an index that can address n items (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NSTRMS   = 64;
  localparam int unsigned NSTRMS_W = idx_width(NSTRMS);
  localparam int unsigned NTAGS    = 16;
  localparam int unsigned TAG_W    = idx_width(NTAGS);
  localparam int unsigned CNT_W    = TAG_W + 1;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned CL_BYTES = 128;
  localparam int unsigned CL_SHIFT = 7;

  typedef logic [NSTRMS_W-1:0] sid_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [CNT_W-1:0]    cnt_t;

endpackage

// File: rtl/l2_tag_pool.sv
// Free-tag pool: lowest-free allocation, release, and outstanding count.
module l2_tag_pool
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_alloc,
  input  logic             i_release,
  input  tag_t             i_release_tag,
  output logic             o_any_free_c,
  output tag_t             o_alloc_tag_c,
  output logic [NTAGS-1:0] o_free,
  output cnt_t             o_outstanding
);

  logic [NTAGS-1:0] r_free;
  logic [NTAGS-1:0] w_alloc_oh;
  logic [NTAGS-1:0] w_release_oh;
  logic [NTAGS-1:0] w_free_next;
  cnt_t             w_free_cnt;
  cnt_t             r_outstanding;
  tag_t             w_lowest;

  // Lowest-index free tag from the registered mask only.
  always_comb begin
    w_lowest = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (r_free[i]) w_lowest = TAG_W'(i);
    end
  end

  // Next free mask and its population count.
  always_comb begin
    w_alloc_oh   = '0;
    w_release_oh = '0;
    if (i_alloc)   w_alloc_oh[w_lowest]        = 1'b1;
    if (i_release) w_release_oh[i_release_tag] = 1'b1;
    w_free_next = (r_free & ~w_alloc_oh) | w_release_oh;
    w_free_cnt  = '0;
    for (int i = 0; i < NTAGS; i++) begin
      w_free_cnt = w_free_cnt + CNT_W'(w_free_next[i]);
    end
  end

  // Free mask and outstanding counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free        <= '1;
      r_outstanding <= '0;
    end else begin
      r_free        <= w_free_next;
      r_outstanding <= CNT_W'(NTAGS) - w_free_cnt;
    end
  end

  assign o_any_free_c  = |r_free;
  assign o_alloc_tag_c = w_lowest;
  assign o_free        = r_free;
  assign o_outstanding = r_outstanding;

endmodule

// File: rtl/l2_req_responder.sv
// Far-end L2 request responder: per-stream pointers, tagged memory reads,
// out-of-order completions mapped back to stream ids.
module l2_req_responder
  import l2_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_cfg_v,
  output logic  i_cfg_r,
  input  sid_t  i_cfg_sid,
  input  addr_t i_cfg_addr,
  input  logic  i_req_v,
  output logic  i_req_r,
  input  sid_t  i_req_sid,
  output logic  o_mem_v,
  input  logic  o_mem_r,
  output addr_t o_mem_addr,
  output tag_t  o_mem_tag,
  input  logic  i_mem_v,
  output logic  i_mem_r,
  input  tag_t  i_mem_tag,
  output logic  o_rsp_v,
  input  logic  o_rsp_r,
  output sid_t  o_rsp_sid,
  output cnt_t  o_outstanding,
  output logic  o_err
);

  addr_t            r_ptr     [NSTRMS];
  sid_t             r_tag_sid [NTAGS];
  logic             r_mem_v;
  addr_t            r_mem_addr;
  tag_t             r_mem_tag;
  logic             r_rsp_v;
  sid_t             r_rsp_sid;
  logic             r_err;

  logic             w_any_free;
  tag_t             w_alloc_tag;
  logic [NTAGS-1:0] w_free;
  logic             w_req_r;
  logic             w_req_fire;
  logic             w_mem_r;
  logic             w_cpl_fire;
  logic             w_cpl_hit;
  addr_t            w_cfg_ptr;

  // Handshake qualification; config always wins over a request.
  always_comb begin
    w_req_r    = ~i_cfg_v & w_any_free & (~r_mem_v | o_mem_r);
    w_req_fire = i_req_v & w_req_r;
    w_mem_r    = ~r_rsp_v | o_rsp_r;
    w_cpl_fire = i_mem_v & w_mem_r;
    w_cpl_hit  = w_cpl_fire & ~w_free[i_mem_tag];
    w_cfg_ptr  = i_cfg_addr & ~addr_t'(CL_BYTES - 1);
  end

  l2_tag_pool u_tag_pool (
    .clk           (clk),
    .rst_n         (reset),
    .i_alloc       (w_req_fire),
    .i_release     (w_cpl_hit),
    .i_release_tag (i_mem_tag),
    .o_any_free_c  (w_any_free),
    .o_alloc_tag_c (w_alloc_tag),
    .o_free        (w_free),
    .o_outstanding (o_outstanding)
  );

  // Per-stream cache-line pointer table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSTRMS; i++) r_ptr[i] <= '0;
    end else if (i_cfg_v) begin
      r_ptr[i_cfg_sid] <= w_cfg_ptr;
    end else if (w_req_fire) begin
      r_ptr[i_req_sid] <= r_ptr[i_req_sid] + addr_t'(CL_BYTES);
    end
  end

  // Tag to stream-id map, written at allocation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAGS; i++) r_tag_sid[i] <= '0;
    end else if (w_req_fire) begin
      r_tag_sid[w_alloc_tag] <= i_req_sid;
    end
  end

  // Memory read command output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_v    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_tag  <= '0;
    end else if (w_req_fire) begin
      r_mem_v    <= 1'b1;
      r_mem_addr <= r_ptr[i_req_sid];
      r_mem_tag  <= w_alloc_tag;
    end else if (o_mem_r) begin
      r_mem_v    <= 1'b0;
    end
  end

  // Response output register; completions to free tags produce nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_v   <= 1'b0;
      r_rsp_sid <= '0;
    end else if (w_cpl_hit) begin
      r_rsp_v   <= 1'b1;
      r_rsp_sid <= r_tag_sid[i_mem_tag];
    end else if (o_rsp_r) begin
      r_rsp_v   <= 1'b0;
    end
  end

  // Sticky error: completion for a tag that was not allocated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_cpl_fire && w_free[i_mem_tag]) begin
      r_err <= 1'b1;
    end
  end

  assign i_cfg_r    = 1'b1;
  assign i_req_r    = w_req_r;
  assign i_mem_r    = w_mem_r;
  assign o_mem_v    = r_mem_v;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_tag  = r_mem_tag;
  assign o_rsp_v    = r_rsp_v;
  assign o_rsp_sid  = r_rsp_sid;
  assign o_err      = r_err;

endmodule

// File: tb/tb_l2_req_responder.sv
// Directed self-checking bench for l2_req_responder.
module tb_l2_req_responder;

  logic        clk;
  logic        reset;
  logic        i_cfg_v;
  logic        i_cfg_r;
  logic [5:0]  i_cfg_sid;
  logic [63:0] i_cfg_addr;
  logic        i_req_v;
  logic        i_req_r;
  logic [5:0]  i_req_sid;
  logic        o_mem_v;
  logic        o_mem_r;
  logic [63:0] o_mem_addr;
  logic [3:0]  o_mem_tag;
  logic        i_mem_v;
  logic        i_mem_r;
  logic [3:0]  i_mem_tag;
  logic        o_rsp_v;
  logic        o_rsp_r;
  logic [5:0]  o_rsp_sid;
  logic [4:0]  o_outstanding;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  l2_req_responder dut (
    .clk           (clk),
    .reset         (reset),
    .i_cfg_v       (i_cfg_v),
    .i_cfg_r       (i_cfg_r),
    .i_cfg_sid     (i_cfg_sid),
    .i_cfg_addr    (i_cfg_addr),
    .i_req_v       (i_req_v),
    .i_req_r       (i_req_r),
    .i_req_sid     (i_req_sid),
    .o_mem_v       (o_mem_v),
    .o_mem_r       (o_mem_r),
    .o_mem_addr    (o_mem_addr),
    .o_mem_tag     (o_mem_tag),
    .i_mem_v       (i_mem_v),
    .i_mem_r       (i_mem_r),
    .i_mem_tag     (i_mem_tag),
    .o_rsp_v       (o_rsp_v),
    .o_rsp_r       (o_rsp_r),
    .o_rsp_sid     (o_rsp_sid),
    .o_outstanding (o_outstanding),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle();
    i_cfg_v = 1'b0; i_cfg_sid = '0; i_cfg_addr = '0;
    i_req_v = 1'b0; i_req_sid = '0;
    i_mem_v = 1'b0; i_mem_tag = '0;
    o_mem_r = 1'b1; o_rsp_r = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    #2;
    total++; if (o_mem_v !== 1'b0) begin bad++; $display("FAIL rst_mem_v got=%b exp=0", o_mem_v); end
    total++; if (o_rsp_v !== 1'b0) begin bad++; $display("FAIL rst_rsp_v got=%b exp=0", o_rsp_v); end
    total++; if (o_outstanding !== 5'd0) begin bad++; $display("FAIL rst_outstanding got=%0d exp=0", o_outstanding); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", o_err); end
    total++; if (o_mem_addr !== 64'd0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", o_mem_addr); end
    total++; if (o_mem_tag !== 4'd0) begin bad++; $display("FAIL rst_mem_tag got=%0d exp=0", o_mem_tag); end
    total++; if (o_rsp_sid !== 6'd0) begin bad++; $display("FAIL rst_rsp_sid got=%0d exp=0", o_rsp_sid); end
    total++; if (i_cfg_r !== 1'b1) begin bad++; $display("FAIL rst_cfg_r got=%b exp=1", i_cfg_r); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (i_req_r !== 1'b1) begin bad++; $display("FAIL rst_req_r got=%b exp=1", i_req_r); end
    total++; if (i_mem_r !== 1'b1) begin bad++; $display("FAIL rst_mem_r got=%b exp=1", i_mem_r); end
  endtask

  task automatic test_stream();
    logic [63:0] ea;
    do_reset();
    i_cfg_v = 1'b1; i_cfg_sid = 6'd5; i_cfg_addr = 64'h1000_0047;
    @(negedge clk);
    i_cfg_v = 1'b0; i_req_v = 1'b1; i_req_sid = 6'd5;
    #1;
    total++; if (i_req_r !== 1'b1) begin bad++; $display("FAIL stream_req_r got=%b exp=1", i_req_r); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ea = 64'h1000_0000 + 64'(k) * 64'd128;
      total++; if (o_mem_v !== 1'b1) begin bad++; $display("FAIL stream_mem_v[%0d] got=%b exp=1", k, o_mem_v); end
      total++; if (o_mem_addr !== ea) begin bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", k, o_mem_addr, ea); end
      total++; if (o_mem_tag !== 4'(k)) begin bad++; $display("FAIL stream_tag[%0d] got=%0d exp=%0d", k, o_mem_tag, k); end
      if (k == 2) i_req_v = 1'b0;
    end
    @(negedge clk);
    total++; if (o_mem_v !== 1'b0) begin bad++; $display("FAIL stream_mem_v_drop got=%b exp=0", o_mem_v); end
    total++; if (o_outstanding !== 5'd3) begin bad++; $display("FAIL stream_outstanding got=%0d exp=3", o_outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    i_req_v = 1'b1; i_req_sid = 6'd1;
    repeat (16) @(negedge clk);
    #1;
    total++; if (o_outstanding !== 5'd16) begin bad++; $display("FAIL full_outstanding got=%0d exp=16", o_outstanding); end
    total++; if (i_req_r !== 1'b0) begin bad++; $display("FAIL full_req_r got=%b exp=0", i_req_r); end
    total++; if (o_mem_tag !== 4'd15) begin bad++; $display("FAIL full_last_tag got=%0d exp=15", o_mem_tag); end
    i_mem_v = 1'b1; i_mem_tag = 4'd7;
    @(negedge clk);
    i_mem_v = 1'b0;
    #1;
    total++; if (i_req_r !== 1'b1) begin bad++; $display("FAIL full_req_r_after_rel got=%b exp=1", i_req_r); end
    total++; if (o_outstanding !== 5'd15) begin bad++; $display("FAIL full_outstanding_rel got=%0d exp=15", o_outstanding); end
    total++; if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd1) begin bad++; $display("FAIL full_rsp got=%b/%0d exp=1/1", o_rsp_v, o_rsp_sid); end
    total++; if (o_mem_v !== 1'b0) begin bad++; $display("FAIL full_stall_mem_v got=%b exp=0", o_mem_v); end
    @(negedge clk);
    total++; if (o_mem_v !== 1'b1 || o_mem_tag !== 4'd7) begin bad++; $display("FAIL full_reissue got=%b/%0d exp=1/7", o_mem_v, o_mem_tag); end
    total++; if (o_mem_addr !== 64'h800) begin bad++; $display("FAIL full_reissue_addr got=%h exp=800", o_mem_addr); end
    total++; if (o_outstanding !== 5'd16) begin bad++; $display("FAIL full_outstanding_re got=%0d exp=16", o_outstanding); end
    i_req_v = 1'b0;
  endtask

  task automatic test_out_of_order();
    do_reset();
    i_req_v = 1'b1; i_req_sid = 6'd9;
    @(negedge clk); i_req_sid = 6'd3;
    @(negedge clk); i_req_sid = 6'd4;
    @(negedge clk); i_req_v = 1'b0;
    o_rsp_r = 1'b0; i_mem_v = 1'b1; i_mem_tag = 4'd2;
    #1;
    total++; if (i_mem_r !== 1'b1) begin bad++; $display("FAIL ooo_mem_r_idle got=%b exp=1", i_mem_r); end
    @(negedge clk);
    i_mem_tag = 4'd0;
    #1;
    total++; if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd4) begin bad++; $display("FAIL ooo_rsp0 got=%b/%0d exp=1/4", o_rsp_v, o_rsp_sid); end
    total++; if (i_mem_r !== 1'b0) begin bad++; $display("FAIL ooo_mem_r_bp got=%b exp=0", i_mem_r); end
    @(negedge clk);
    total++; if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd4) begin bad++; $display("FAIL ooo_rsp0_hold got=%b/%0d exp=1/4", o_rsp_v, o_rsp_sid); end
    o_rsp_r = 1'b1;
    @(negedge clk);
    total++; if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd9) begin bad++; $display("FAIL ooo_rsp1 got=%b/%0d exp=1/9", o_rsp_v, o_rsp_sid); end
    i_mem_tag = 4'd1;
    @(negedge clk);
    total++; if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd3) begin bad++; $display("FAIL ooo_rsp2 got=%b/%0d exp=1/3", o_rsp_v, o_rsp_sid); end
    i_mem_v = 1'b0;
    @(negedge clk);
    total++; if (o_rsp_v !== 1'b0) begin bad++; $display("FAIL ooo_rsp_drain got=%b exp=0", o_rsp_v); end
    total++; if (o_outstanding !== 5'd0) begin bad++; $display("FAIL ooo_outstanding got=%0d exp=0", o_outstanding); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL ooo_err got=%b exp=0", o_err); end
  endtask

  task automatic test_alloc_release();
    do_reset();
    i_req_v = 1'b1; i_req_sid = 6'd2;
    @(negedge clk);
    i_mem_v = 1'b1; i_mem_tag = 4'd0;
    @(negedge clk);
    i_mem_v = 1'b0;
    total++; if (o_outstanding !== 5'd1) begin bad++; $display("FAIL ar_outstanding got=%0d exp=1", o_outstanding); end
    total++; if (o_mem_tag !== 4'd1) begin bad++; $display("FAIL ar_tag got=%0d exp=1", o_mem_tag); end
    total++; if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'd2) begin bad++; $display("FAIL ar_rsp got=%b/%0d exp=1/2", o_rsp_v, o_rsp_sid); end
    @(negedge clk);
    i_req_v = 1'b0;
    total++; if (o_mem_tag !== 4'd0) begin bad++; $display("FAIL ar_reuse_tag got=%0d exp=0", o_mem_tag); end
    total++; if (o_outstanding !== 5'd2) begin bad++; $display("FAIL ar_outstanding2 got=%0d exp=2", o_outstanding); end
  endtask

  task automatic test_wrap();
    do_reset();
    i_cfg_v = 1'b1; i_cfg_sid = 6'd63; i_cfg_addr = 64'hFFFF_FFFF_FFFF_FF80;
    @(negedge clk);
    i_cfg_v = 1'b0; i_req_v = 1'b1; i_req_sid = 6'd63;
    @(negedge clk);
    total++; if (o_mem_addr !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL wrap_addr0 got=%h exp=ffffffffffffff80", o_mem_addr); end
    @(negedge clk);
    i_req_v = 1'b0;
    total++; if (o_mem_v !== 1'b1 || o_mem_addr !== 64'h0) begin bad++; $display("FAIL wrap_addr1 got=%b/%h exp=1/0", o_mem_v, o_mem_addr); end
  endtask

  task automatic test_cfg_priority();
    do_reset();
    i_cfg_v = 1'b1; i_cfg_sid = 6'd7; i_cfg_addr = 64'h2000;
    i_req_v = 1'b1; i_req_sid = 6'd7;
    #1;
    total++; if (i_req_r !== 1'b0) begin bad++; $display("FAIL prio_req_r got=%b exp=0", i_req_r); end
    @(negedge clk);
    i_cfg_v = 1'b0;
    #1;
    total++; if (o_mem_v !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b exp=0", o_mem_v); end
    total++; if (i_req_r !== 1'b1) begin bad++; $display("FAIL prio_req_r2 got=%b exp=1", i_req_r); end
    @(negedge clk);
    i_req_v = 1'b0;
    total++; if (o_mem_v !== 1'b1 || o_mem_addr !== 64'h2000) begin bad++; $display("FAIL prio_addr got=%b/%h exp=1/2000", o_mem_v, o_mem_addr); end
  endtask

  task automatic test_err_and_reset();
    do_reset();
    i_mem_v = 1'b1; i_mem_tag = 4'd12;
    @(negedge clk);
    i_mem_v = 1'b0;
    total++; if (o_rsp_v !== 1'b0) begin bad++; $display("FAIL err_rsp_v got=%b exp=0", o_rsp_v); end
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", o_err); end
    total++; if (o_outstanding !== 5'd0) begin bad++; $display("FAIL err_outstanding got=%0d exp=0", o_outstanding); end
    repeat (3) @(negedge clk);
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", o_err); end
    i_req_v = 1'b1; i_req_sid = 6'd0; o_mem_r = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (o_outstanding !== 5'd3) begin bad++; $display("FAIL mid_outstanding got=%0d exp=3", o_outstanding); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (o_mem_v !== 1'b0 || o_rsp_v !== 1'b0) begin bad++; $display("FAIL async_v got=%b/%b exp=0/0", o_mem_v, o_rsp_v); end
    total++; if (o_outstanding !== 5'd0) begin bad++; $display("FAIL async_outstanding got=%0d exp=0", o_outstanding); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL async_err got=%b exp=0", o_err); end
    idle();
    @(negedge clk);
    reset = 1'b1;
    i_mem_v = 1'b1; i_mem_tag = 4'd0;
    @(negedge clk);
    i_mem_v = 1'b0;
    total++; if (o_rsp_v !== 1'b0) begin bad++; $display("FAIL discard_rsp got=%b exp=0", o_rsp_v); end
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL discard_err got=%b exp=1", o_err); end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_stream();
    test_full();
    test_out_of_order();
    test_alloc_release();
    test_wrap();
    test_cfg_priority();
    test_err_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_req_responder.md
Name: l2_req_responder

Overview:
- Far end of the L2 OpenCAPI request/response interface.
- Accepts per-stream cache-line read requests (stream id only) and turns each into a memory read command, using a per-stream address pointer and an allocated tag.
- Memory completions may arrive out of order. Each completion maps its tag back to a stream id, which is returned on the response interface.
- Sits between the L2 controller's request merge and the host/memory command port; also serves as the bench/emulation responder.

Parameters:
- nstrms, 64, number of streams.
- nstrms_width, $clog2(nstrms), stream id width.
- ntags, 16, maximum outstanding memory reads.
- tag_width, $clog2(ntags), tag width.
- addr_width, 64, byte address width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- i_cfg_v  input  1  per-stream base-address write valid.
- i_cfg_r  output  1  config ready.
- i_cfg_sid  input  nstrms_width  stream being configured.
- i_cfg_addr  input  addr_width  new pointer; low 7 bits ignored (forced 0).
- i_req_v  input  1  request valid.
- i_req_r  output  1  request ready.
- i_req_sid  input  nstrms_width  requesting stream.
- o_mem_v  output  1  memory read command valid.
- o_mem_r  input  1  memory command ready.
- o_mem_addr  output  addr_width  cache-line address.
- o_mem_tag  output  tag_width  allocated tag.
- i_mem_v  input  1  completion valid.
- i_mem_r  output  1  completion ready.
- i_mem_tag  input  tag_width  completing tag.
- o_rsp_v  output  1  response valid.
- o_rsp_r  input  1  response ready.
- o_rsp_sid  output  nstrms_width  stream the response belongs to.
- o_outstanding  output  tag_width+1  tags currently allocated.
- o_err  output  1  sticky: completion arrived for an unallocated tag.

Behaviour:
- Reset (reset low, async):
  - all pointers = 0; all tags free.
  - o_mem_v = 0, o_rsp_v = 0, o_outstanding = 0, o_err = 0.
  - o_mem_addr, o_mem_tag, o_rsp_sid = 0.
- Handshakes: transfer occurs on v & r. v holds stable until accepted. No ready depends combinationally on the same interface's valid.
- Config:
  - i_cfg_r = 1 always.
  - On transfer, ptr[sid] <= {i_cfg_addr[addr_width-1:7], 7'b0}.
  - Config has priority. i_req_r = 0 in any cycle with i_cfg_v = 1, so a request and a config never update the table in the same cycle.
- Request path:
  - i_req_r = ~i_cfg_v & any_free & (~o_mem_v | o_mem_r).
  - any_free comes from the registered free mask.
  - On accept, the next cycle shows:
    - o_mem_v = 1;
    - o_mem_addr = ptr[sid] (pre-increment value);
    - o_mem_tag = lowest-index free tag.
  - Also on accept: tag_sid[tag] <= sid; ptr[sid] <= ptr[sid] + 128, wrapping modulo 2^addr_width.
  - Latency: 1 cycle. Back-to-back accept at full rate while o_mem_r = 1 and tags are available.
- Completion path:
  - i_mem_r = ~o_rsp_v | o_rsp_r, a single output register.
  - On accept with tag allocated: o_rsp_v <= 1 next cycle, o_rsp_sid <= tag_sid[tag], tag freed.
  - On accept with tag free: completion consumed, no response, o_err <= 1 (sticky until reset), free mask unchanged.
- Tag pool:
  - free_next = (free & ~alloc_onehot) | release_onehot.
  - A tag released in cycle N is allocatable from N+1 only.
  - Allocate and release in the same cycle (different tags) are both honoured.
  - The same tag cannot be in both sets, because allocation only selects from the registered free mask.
- o_outstanding = ntags − popcount(free), registered. Same-cycle alloc + release leaves it unchanged.
- Full: when all ntags tags are allocated, i_req_r = 0 until a completion is accepted. The request is then accepted the cycle after the release.
- Response order follows completion order, not request order.
- Reset mid-operation: all in-flight tags are discarded, and no responses are generated for them after reset.

Decomposition:
- l2_pkg holds:
  - CL_BYTES = 128 and CL_SHIFT = 7;
  - function clog2-based width helpers;
  - typedefs sid_t, tag_t, addr_t.
- Sub-module l2_tag_pool:
  - owns the free mask, lowest-free priority encode, alloc/release update and popcount;
  - outputs any_free, alloc_tag, outstanding.
- The top holds:
  - ptr table (nstrms × addr_width regs);
  - tag_sid table (ntags × nstrms_width);
  - the two output registers;
  - the error flag.

Test Plan:
- Reset then cfg sid 5 addr 0x1000_0047, then 3 reqs sid 5 with o_mem_r = 1 -> o_mem_addr 0x1000_0000, 0x1000_0080, 0x1000_0100 on consecutive cycles; tags 0, 1, 2.
- 16 reqs, no completions -> o_outstanding = 16, i_req_r = 0. Complete tag 7 -> next request issued with tag 7 one cycle after release.
- Completions for tags 2, 0, 1 (sids 9, 3, 4) in that order -> o_rsp_sid 4, 9, 3. With o_rsp_r = 0, i_mem_r drops after the first completion, and none are lost.
- cfg sid 63 addr 0xFFFF_FFFF_FFFF_FF80, then 2 reqs -> addresses 0xFFFF_FFFF_FFFF_FF80, then 0x0 (wrap).
- i_cfg_v and i_req_v in the same cycle for the same sid -> request stalled 1 cycle, then issued at the new config address.
- Completion with tag 12 never allocated -> no o_rsp_v, o_err = 1 and stays 1. Assert reset mid-traffic -> o_outstanding = 0 and all v outputs 0 immediately (async).
